fifo_rd_burst: RTL and testbench

FIFO_RD_BURST -- requirements
Module: fifo_rd_burst

---
 rtl/fifo_tb_pkg.sv | 13 +
 rtl/fifo_skid2.sv | 53 +++++
 rtl/fifo_rd_burst.sv | 96 +++++++++
 tb/tb_fifo_rd_burst.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tb_pkg.sv
// Shared definitions for the burst FIFO reader: FSM encoding and default widths.
package fifo_tb_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 5;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer: accepts one word per cycle, presents the oldest entry.
module fifo_skid2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        occ_o
);
    logic [DATA_W-1:0] e0_q, e1_q;
    logic [1:0]        occ_q;
    logic              pop;

    assign pop = out_ready_i && (occ_q != 2'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            case ({in_valid_i, pop})
                2'b10: begin
                    if (occ_q == 2'd0) e0_q <= in_data_i;
                    else               e1_q <= in_data_i;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    occ_q <= occ_q - 2'd1;
                end
                // Simultaneous push and pop: occupancy unchanged, order kept.
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        e0_q <= in_data_i;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data_o  = e0_q;
    assign out_valid_o = (occ_q != 2'd0);
    assign occ_o       = occ_q;
endmodule

// File: rtl/fifo_rd_burst.sv
// Reads a burst of len words from a FIFO with 1-cycle read latency and streams them out.
module fifo_rd_burst
    import fifo_tb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              empty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  xfer_cnt
);
    state_e           state_q;
    logic [LEN_W-1:0] issue_left_q, deliver_left_q, xfer_cnt_q;
    logic             inflight_q, done_q, busy_q;
    logic [1:0]       occ;
    logic             xfer;
    logic [2:0]       pend;

    assign xfer = m_valid && m_ready;
    // Words owed to the buffer after this edge; counting the departing word keeps 1 word/cycle.
    assign pend = 3'(occ) + 3'(inflight_q) - 3'(xfer);

    assign rd_en = (state_q == ST_RUN) && !empty && (issue_left_q != '0) && (pend < 3'd2);

    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            xfer_cnt_q     <= '0;
            inflight_q     <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            done_q     <= 1'b0;
            if (xfer) begin
                deliver_left_q <= deliver_left_q - LEN_W'(1);
                xfer_cnt_q     <= xfer_cnt_q + LEN_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state_q        <= ST_RUN;
                        issue_left_q   <= len;
                        deliver_left_q <= len;
                        xfer_cnt_q     <= '0;
                        busy_q         <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        issue_left_q <= issue_left_q - LEN_W'(1);
                        if (issue_left_q == LEN_W'(1)) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (xfer && (deliver_left_q == LEN_W'(1))) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk_i       (rd_clk),
        .rst_ni      (rst),
        .in_data_i   (rdata),
        .in_valid_i  (inflight_q),
        .out_data_o  (m_data),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .occ_o       (occ)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_fifo_rd_burst.sv
// Directed + randomized bench for fifo_rd_burst with a FIFO model and an order scoreboard.
module tb_fifo_rd_burst;
    import fifo_tb_pkg::*;

    localparam int MEMD = 1024;

    logic       rd_clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic       empty;
    logic [7:0] rdata = '0;
    logic       rd_en, m_valid, m_ready = 1'b0, busy, done;
    logic [7:0] m_data;
    logic [4:0] xfer_cnt;

    fifo_rd_burst #(.DATA_W(8), .LEN_W(5)) dut (
        .rd_clk(rd_clk), .rst(rst), .start(start), .len(len), .empty(empty),
        .rdata(rdata), .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .done(done), .xfer_cnt(xfer_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: one-cycle read latency, pointers only ever grow.
    logic [7:0] mem [MEMD];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (rd_ptr == wr_ptr);
    always @(posedge rd_clk) begin
        if (rd_en && (rd_ptr != wr_ptr)) begin
            rdata  <= mem[rd_ptr % MEMD];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int npass = 0, nfail = 0, ntot = 0;
    logic [7:0] sb[$];
    int idx, nrd, nxf, ndone, first_rd, last_rd, first_mv, last_xf, done_idx, max_pend, nviol;
    logic [7:0] first_data, hold_data;
    logic hold_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % MEMD] = v;
        wr_ptr++;
    endtask

    task automatic clear_stats();
        idx = -2; nrd = 0; nxf = 0; ndone = 0; first_rd = -1; last_rd = -1;
        first_mv = -1; last_xf = -1; done_idx = -1; max_pend = 0; nviol = 0; first_data = 'x;
    endtask

    // Observe one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic sample();
        logic [7:0] e;
        @(negedge rd_clk);
        idx++;
        if (!rst) begin
            sb.delete();
            hold_prev = 1'b0;
        end
        if (rd_en) begin
            nrd++;
            if (first_rd < 0) first_rd = idx;
            last_rd = idx;
            if (empty) nviol++;
            else sb.push_back(mem[rd_ptr % MEMD]);
        end
        if (hold_prev && m_valid) chk("m_data_hold", m_data, hold_data);
        if (m_valid && m_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("m_data_order", m_data, e);
            end
            if (nxf == 0) first_data = m_data;
            nxf++;
            last_xf = idx;
        end
        if (m_valid && first_mv < 0) first_mv = idx;
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;
        if (sb.size() > max_pend) max_pend = sb.size();
        if (done) begin
            ndone++;
            done_idx = idx;
        end
        @(posedge rd_clk);
        #1;
    endtask

    task automatic start_burst(input logic [4:0] l);
        clear_stats();
        start = 1'b1;
        len = l;
        sample();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && ndone == 0; i++) sample();
        if (ndone == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        rst = 1'b1;
        @(posedge rd_clk);
        #1;

        // Full-rate burst of 5.
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        m_ready = 1'b1;
        start_burst(5);
        wait_done(30);
        chk("b5_first_rd", first_rd, 0);
        chk("b5_last_rd", last_rd, 4);
        chk("b5_rd_cnt", nrd, 5);
        chk("b5_first_mv", first_mv, 2);
        chk("b5_done_gap", done_idx, last_xf + 1);
        chk("b5_nxf", nxf, 5);
        chk("b5_xfer_cnt", xfer_cnt, 5);
        chk("b5_busy_after", busy, 0);

        // Back-pressure from the first valid word.
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        m_ready = 1'b0;
        start_burst(4);
        for (int i = 0; i < 10 && first_mv < 0; i++) sample();
        repeat (6) sample();
        chk("bp_rd_at_most_2", nrd <= 2, 1);
        chk("bp_m_data", m_data, 8'h20);
        chk("bp_m_valid", m_valid, 1);
        m_ready = 1'b1;
        wait_done(30);
        chk("bp_nxf", nxf, 4);
        chk("bp_xfer_cnt", xfer_cnt, 4);
        chk("bp_ndone", ndone, 1);

        // Empty stall mid-burst, then refill.
        push(8'h30); push(8'h31);
        start_burst(6);
        repeat (10) sample();
        chk("st_busy", busy, 1);
        chk("st_nrd", nrd, 2);
        chk("st_nxf", nxf, 2);
        chk("st_ndone", ndone, 0);
        for (int i = 0; i < 4; i++) push(8'h32 + 8'(i));
        wait_done(30);
        chk("st_xfer_cnt", xfer_cnt, 6);
        chk("st_ndone_end", ndone, 1);

        // Zero-length start is ignored; a start during RUN is ignored.
        for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
        start_burst(0);
        repeat (3) sample();
        chk("z_nrd", nrd, 0);
        chk("z_busy", busy, 0);
        chk("z_ndone", ndone, 0);
        start_burst(3);
        sample();
        start = 1'b1;
        len = 5'd7;
        sample();
        start = 1'b0;
        wait_done(30);
        chk("r_nrd", nrd, 3);
        chk("r_xfer_cnt", xfer_cnt, 3);
        chk("r_ndone", ndone, 1);
        repeat (3) sample();
        chk("r_busy_idle", busy, 0);
        chk("r_no_extra_rd", nrd, 3);

        // Reset right after reads are in flight.
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        start_burst(6);
        sample();
        sample();
        rst = 1'b0;
        #1;
        chk("mr_rd_en", rd_en, 0);
        chk("mr_m_valid", m_valid, 0);
        chk("mr_m_data", m_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_xfer_cnt", xfer_cnt, 0);
        sample();
        sample();
        chk("mr_no_done", ndone, 0);
        rst = 1'b1;
        start_burst(3);
        wait_done(30);
        chk("mr_fresh_word", first_data, 8'h42);
        chk("mr_nxf", nxf, 3);
        chk("mr_ndone", ndone, 1);

        // Random back-pressure, long burst, FIFO kept topped up.
        start_burst(31);
        for (int i = 0; i < 600 && ndone == 0; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (wr_ptr - rd_ptr < FIFO_DEPTH) push(8'($urandom_range(0, 255)));
            sample();
        end
        if (ndone == 0) chk("rnd_timeout", 0, 1);
        chk("rnd_nxf", nxf, 31);
        chk("rnd_xfer_cnt", xfer_cnt, 31);
        chk("rnd_ndone", ndone, 1);
        chk("rnd_pend_le2", max_pend <= 2, 1);
        chk("rnd_rd_while_empty", nviol, 0);
        chk("rnd_sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
